// File: rtl/pcm_out_reader_if.sv
// pcm_out_reader_if
// Bundles the PCM buffer read port and the sample output of the reader.
//   addr       : RAM read address (current read pointer), driven by the reader
//   d_in       : RAM read data, channel c at bits [c*DATA_W +: DATA_W]
//   dout       : registered output samples, same packing as d_in
//   dout_valid : one-cycle pulse when dout updates
// master = the reader, slave = RAM plus downstream consumer.
interface pcm_out_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    logic [ADDR_W-1:0]        addr;
    logic [NUM_CH*DATA_W-1:0] d_in;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     dout_valid;

    modport master (output addr, input d_in, output dout, output dout_valid);
    modport slave  (input addr, output d_in, input dout, input dout_valid);
endinterface

// File: rtl/pcm_out_reader.sv
// pcm_out_reader
// Drains decoded PCM samples from a ping-pong ring region of the PCM buffer
// RAM, one address per rising edge of the asynchronous sample clock, and
// trades half-buffer credits with the decoder.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   clr            : synchronous clear, same effect as reset, highest priority
//   sample_clk     : asynchronous sample-rate clock, rising edge = one sample
//   frame_done     : decoder filled one half of the ring (credit +1)
//   bus            : RAM read port (addr/d_in) and output word (dout/dout_valid)
//   half_free      : pulse, a half has been consumed and may be refilled
//   underrun       : sticky, a sample was muted for lack of credit
//   overflow       : sticky, frame_done arrived with both halves already full
//   missed         : sticky, a sample edge arrived while a fetch was in flight
module pcm_out_reader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int BASE_ADDR = 448,
    parameter int DEPTH     = 576,
    parameter int RD_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             sample_clk,
    input  logic             frame_done,
    pcm_out_reader_if.master bus,
    output logic             half_free,
    output logic             underrun,
    output logic             overflow,
    output logic             missed
);
    localparam int W     = NUM_CH * DATA_W;
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] MID_A    = ADDR_W'(BASE_ADDR + DEPTH / 2 - 1);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LAT);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              rd_mode_q, rd_mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [W-1:0]      dout_q, dout_d;
    logic              vld_q, vld_d;
    logic              half_free_q, half_free_d;
    logic [1:0]        avail_q, avail_d;
    logic              underrun_q, underrun_d;
    logic              overflow_q, overflow_d;
    logic              missed_q, missed_d;
    logic              edge_det;
    logic              consume;

    assign edge_det = s2_q & ~s3_q;

    always_comb begin
        s1_d        = sample_clk;
        s2_d        = s1_q;
        s3_d        = s2_q;
        state_d     = state_q;
        lat_d       = lat_q;
        rd_mode_d   = rd_mode_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        vld_d       = 1'b0;
        avail_d     = avail_q;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        missed_d    = missed_q;
        consume     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d   = FETCH;
                    lat_d     = LAT_INIT;
                    // Credit is judged once, at edge time; a half released
                    // during the fetch cannot turn this sample into a mute.
                    rd_mode_d = (avail_q != 2'd0);
                end
            end
            FETCH: begin
                if (edge_det) begin
                    missed_d = 1'b1;
                end
                if (lat_q == LAT_LAST) begin
                    state_d = IDLE;
                    vld_d   = 1'b1;
                    if (rd_mode_q) begin
                        dout_d  = bus.d_in;
                        addr_d  = (addr_q == LAST_A) ? FIRST_A : addr_q + 1'b1;
                        consume = (addr_q == MID_A) || (addr_q == LAST_A);
                    end else begin
                        dout_d     = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
        endcase

        half_free_d = consume;

        // A refill arriving together with a release leaves the credit unchanged.
        unique case ({frame_done, consume})
            2'b10: begin
                if (avail_q == 2'd2) begin
                    overflow_d = 1'b1;
                end else begin
                    avail_d = avail_q + 2'd1;
                end
            end
            2'b01:   avail_d = avail_q - 2'd1;
            default: avail_d = avail_q;
        endcase

        if (clr) begin
            s1_d        = 1'b0;
            s2_d        = 1'b0;
            s3_d        = 1'b0;
            state_d     = IDLE;
            lat_d       = '0;
            rd_mode_d   = 1'b0;
            addr_d      = FIRST_A;
            dout_d      = '0;
            vld_d       = 1'b0;
            half_free_d = 1'b0;
            avail_d     = 2'd0;
            underrun_d  = 1'b0;
            overflow_d  = 1'b0;
            missed_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            state_q     <= IDLE;
            lat_q       <= '0;
            rd_mode_q   <= 1'b0;
            addr_q      <= FIRST_A;
            dout_q      <= '0;
            vld_q       <= 1'b0;
            half_free_q <= 1'b0;
            avail_q     <= 2'd0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            state_q     <= state_d;
            lat_q       <= lat_d;
            rd_mode_q   <= rd_mode_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            half_free_q <= half_free_d;
            avail_q     <= avail_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            missed_q    <= missed_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign half_free      = half_free_q;
    assign underrun       = underrun_q;
    assign overflow       = overflow_q;
    assign missed         = missed_q;
endmodule

// File: tb/tb_pcm_out_reader.sv
// tb_pcm_out_reader
// Runs two readers side by side from shared stimulus: u_a with the default
// configuration (NUM_CH=2, RD_LAT=1) and u_b with NUM_CH=4, RD_LAT=3.
// A transaction-level model (ring index, credit count, sticky flags) predicts
// every output word, half_free pulse, pointer value and flag state.
module tb_pcm_out_reader;
    localparam int DEPTH = 576;
    localparam int BASE  = 448;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n, clr, sample_clk, fd_a, fd_b;
    logic hf_a, ur_a, ov_a, ms_a;
    logic hf_b, ur_b, ov_b, ms_b;

    pcm_out_reader_if #(.ADDR_W(10), .DATA_W(16), .NUM_CH(2)) bus_a ();
    pcm_out_reader_if #(.ADDR_W(10), .DATA_W(16), .NUM_CH(4)) bus_b ();

    pcm_out_reader #(.ADDR_W(10), .DATA_W(16), .NUM_CH(2), .BASE_ADDR(BASE),
                     .DEPTH(DEPTH), .RD_LAT(LAT_A)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sample_clk(sample_clk),
        .frame_done(fd_a), .bus(bus_a), .half_free(hf_a), .underrun(ur_a),
        .overflow(ov_a), .missed(ms_a));

    pcm_out_reader #(.ADDR_W(10), .DATA_W(16), .NUM_CH(4), .BASE_ADDR(BASE),
                     .DEPTH(DEPTH), .RD_LAT(LAT_B)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sample_clk(sample_clk),
        .frame_done(fd_b), .bus(bus_b), .half_free(hf_b), .underrun(ur_b),
        .overflow(ov_b), .missed(ms_b));

    always #5 clk = ~clk;

    // RAM contents: ch0=~addr, ch1=addr, ch2=~addr^5A00, ch3=addr^A500
    function automatic logic [63:0] ram_word(input logic [9:0] a);
        logic [15:0] w;
        w = {6'd0, a};
        return {w ^ 16'hA500, ~w ^ 16'h5A00, w, ~w};
    endfunction

    wire [63:0] word_a = ram_word(bus_a.addr);
    wire [63:0] word_b = ram_word(bus_b.addr);
    logic [31:0] pipe_a;
    logic [63:0] pipe_b0, pipe_b1, pipe_b2;
    always @(posedge clk) begin
        pipe_a  <= word_a[31:0];
        pipe_b0 <= word_b;
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
    end
    assign bus_a.d_in = pipe_a;
    assign bus_b.d_in = pipe_b2;

    int vcnt_a = 0;
    int vcnt_b = 0;
    always @(negedge clk) begin
        if (bus_a.dout_valid) vcnt_a <= vcnt_a + 1;
        if (bus_b.dout_valid) vcnt_b <= vcnt_b + 1;
    end

    int errors = 0;
    int checks = 0;

    // reference model
    int m_ptr, m_avail;
    bit m_underrun, m_overflow, m_missed_a, m_missed_b;

    task automatic model_reset();
        m_ptr = 0; m_avail = 0;
        m_underrun = 0; m_overflow = 0; m_missed_a = 0; m_missed_b = 0;
    endtask

    task automatic clr_dut();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_reset();
    endtask

    task automatic pulse_fd();
        @(negedge clk); fd_a = 1'b1; fd_b = 1'b1;
        @(negedge clk); fd_a = 1'b0; fd_b = 1'b0;
        if (m_avail == 2) m_overflow = 1; else m_avail++;
    endtask

    task automatic check_flags(input string nm);
        checks++;
        if ({ur_a, ov_a, ms_a} !== {m_underrun, m_overflow, m_missed_a}) begin
            errors++;
            $display("FAIL %s flags_a {ur,ov,ms} got=%b exp=%b", nm,
                     {ur_a, ov_a, ms_a}, {m_underrun, m_overflow, m_missed_a});
        end
        checks++;
        if ({ur_b, ov_b, ms_b} !== {m_underrun, m_overflow, m_missed_b}) begin
            errors++;
            $display("FAIL %s flags_b {ur,ov,ms} got=%b exp=%b", nm,
                     {ur_b, ov_b, ms_b}, {m_underrun, m_overflow, m_missed_b});
        end
    endtask

    // One sample edge; coincide drives frame_done into the cycle where each
    // reader is due to release a half.
    task automatic do_sample(input bit coincide);
        int hi, lo, lat_a, lat_b, np_a, np_b, nh_a, nh_b, nxt;
        logic [31:0] got_a;
        logic [63:0] got_b, want;
        logic [9:0] pre_a, pre_b, old_addr, new_addr;
        logic hfa, hfb;
        bit cons;
        hi = $urandom_range(2, 4);
        lo = $urandom_range(0, 3);
        old_addr = 10'(BASE + m_ptr);
        if (m_avail > 0) begin
            want = ram_word(old_addr);
            cons = (m_ptr == DEPTH / 2 - 1) || (m_ptr == DEPTH - 1);
            nxt  = (m_ptr + 1) % DEPTH;
            if (cons) m_avail--;
        end else begin
            want = '0; cons = 0; nxt = m_ptr; m_underrun = 1;
        end
        if (coincide) begin
            if (m_avail == 2) m_overflow = 1; else m_avail++;
        end
        m_ptr = nxt;
        new_addr = 10'(BASE + m_ptr);
        lat_a = -1; lat_b = -1; np_a = 0; np_b = 0; nh_a = 0; nh_b = 0;
        hfa = 0; hfb = 0; got_a = '0; got_b = '0; pre_a = '0; pre_b = '0;
        @(negedge clk); sample_clk = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin pre_a = bus_a.addr; pre_b = bus_b.addr; end
            if (hf_a) nh_a++;
            if (hf_b) nh_b++;
            if (bus_a.dout_valid) begin
                np_a++;
                if (lat_a < 0) begin lat_a = n; got_a = bus_a.dout; hfa = hf_a; end
            end
            if (bus_b.dout_valid) begin
                np_b++;
                if (lat_b < 0) begin lat_b = n; got_b = bus_b.dout; hfb = hf_b; end
            end
            if (n == hi) sample_clk = 1'b0;
            if (coincide) begin fd_a = (n == 2 + LAT_A); fd_b = (n == 2 + LAT_B); end
        end
        fd_a = 1'b0; fd_b = 1'b0;
        checks++;
        if (lat_a != 3 + LAT_A || np_a != 1) begin
            errors++;
            $display("FAIL sample_lat_a got lat=%0d pulses=%0d exp lat=%0d pulses=1", lat_a, np_a, 3 + LAT_A);
        end
        checks++;
        if (lat_b != 3 + LAT_B || np_b != 1) begin
            errors++;
            $display("FAIL sample_lat_b got lat=%0d pulses=%0d exp lat=%0d pulses=1", lat_b, np_b, 3 + LAT_B);
        end
        checks++;
        if (got_a !== want[31:0]) begin
            errors++;
            $display("FAIL dout_a addr=%0d got=%h exp=%h", old_addr, got_a, want[31:0]);
        end
        checks++;
        if (got_b !== want) begin
            errors++;
            $display("FAIL dout_b addr=%0d got=%h exp=%h", old_addr, got_b, want);
        end
        checks++;
        if (nh_a != int'(cons) || hfa !== cons) begin
            errors++;
            $display("FAIL half_free_a addr=%0d got pulses=%0d at_valid=%b exp=%b", old_addr, nh_a, hfa, cons);
        end
        checks++;
        if (nh_b != int'(cons) || hfb !== cons) begin
            errors++;
            $display("FAIL half_free_b addr=%0d got pulses=%0d at_valid=%b exp=%b", old_addr, nh_b, hfb, cons);
        end
        checks++;
        if (pre_a !== old_addr || bus_a.addr !== new_addr) begin
            errors++;
            $display("FAIL addr_a got pre=%0d post=%0d exp pre=%0d post=%0d", pre_a, bus_a.addr, old_addr, new_addr);
        end
        checks++;
        if (pre_b !== old_addr || bus_b.addr !== new_addr) begin
            errors++;
            $display("FAIL addr_b got pre=%0d post=%0d exp pre=%0d post=%0d", pre_b, bus_b.addr, old_addr, new_addr);
        end
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad_a, bad_b;
        bad_a = 0; bad_b = 0;
        rst_n = 1'b0; clr = 1'b0; sample_clk = 1'b0; fd_a = 1'b0; fd_b = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (100) begin
            @(posedge clk); #1;
            if (bus_a.addr !== 10'd448 || bus_a.dout !== '0 || bus_a.dout_valid !== 1'b0 ||
                {hf_a, ur_a, ov_a, ms_a} !== 4'b0) bad_a++;
            if (bus_b.addr !== 10'd448 || bus_b.dout !== '0 || bus_b.dout_valid !== 1'b0 ||
                {hf_b, ur_b, ov_b, ms_b} !== 4'b0) bad_b++;
        end
        checks++;
        if (bad_a !== 0) begin errors++; $display("FAIL reset_idle_a got bad_cycles=%0d exp=0", bad_a); end
        checks++;
        if (bad_b !== 0) begin errors++; $display("FAIL reset_idle_b got bad_cycles=%0d exp=0", bad_b); end
        check_flags("reset");
    endtask

    task automatic test_full_ring();
        clr_dut();
        pulse_fd();
        pulse_fd();
        repeat (DEPTH) do_sample(1'b0);
        check_flags("ring");
        do_sample(1'b0);        // credits exhausted: must be muted
        check_flags("ring_end");
    endtask

    task automatic test_underrun();
        clr_dut();
        do_sample(1'b0);
        check_flags("underrun");
        pulse_fd();
        do_sample(1'b0);
        check_flags("underrun_recover");
    endtask

    task automatic test_overflow();
        clr_dut();
        repeat (3) pulse_fd();
        check_flags("overflow");
        clr_dut();
        pulse_fd();
        pulse_fd();
        repeat (DEPTH / 2 - 1) do_sample(1'b0);
        do_sample(1'b1);
        check_flags("coincide");
        pulse_fd();             // credit must still be 2 here
        check_flags("coincide_full");
    endtask

    task automatic test_missed();
        logic wave [48];
        int rises[$];
        int i, len, acc_a, acc_b, last_a, last_b, va, vb;
        bit lvl, drop_a, drop_b;
        clr_dut();
        i = 0; lvl = 0;
        while (i < 48) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len && i < 48; j++) begin wave[i] = lvl; i++; end
            lvl = ~lvl;
        end
        for (int k = 44; k < 48; k++) wave[k] = 1'b0;
        for (int k = 0; k < 48; k++)
            if (wave[k] && (k == 0 || !wave[k-1])) rises.push_back(k);
        acc_a = 0; acc_b = 0; last_a = -100; last_b = -100; drop_a = 0; drop_b = 0;
        foreach (rises[k]) begin
            if (rises[k] - last_a > LAT_A) begin acc_a++; last_a = rises[k]; end else drop_a = 1;
            if (rises[k] - last_b > LAT_B) begin acc_b++; last_b = rises[k]; end else drop_b = 1;
        end
        va = vcnt_a; vb = vcnt_b;
        for (int k = 0; k < 48; k++) begin @(negedge clk); sample_clk = wave[k]; end
        @(negedge clk); sample_clk = 1'b0;
        repeat (12) @(negedge clk);
        m_missed_a = drop_a; m_missed_b = drop_b;
        if (acc_a > 0) m_underrun = 1;
        checks++;
        if (vcnt_a - va != acc_a) begin
            errors++; $display("FAIL missed_count_a got=%0d exp=%0d", vcnt_a - va, acc_a);
        end
        checks++;
        if (vcnt_b - vb != acc_b) begin
            errors++; $display("FAIL missed_count_b got=%0d exp=%0d", vcnt_b - vb, acc_b);
        end
        check_flags("missed");
    endtask

    task automatic test_abort(input bit use_rst);
        int va, vb;
        clr_dut();
        pulse_fd();
        pulse_fd();
        do_sample(1'b0);        // leaves a nonzero dout and a moved pointer
        va = vcnt_a; vb = vcnt_b;
        @(negedge clk); sample_clk = 1'b1;
        repeat (3) @(posedge clk);   // FETCH entered at the third edge
        #1;
        sample_clk = 1'b0;
        if (use_rst) rst_n = 1'b0; else clr = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; clr = 1'b0;
        repeat (10) @(negedge clk);
        model_reset();
        checks++;
        if (vcnt_a != va || vcnt_b != vb) begin
            errors++;
            $display("FAIL abort_valid rst=%0b got pulses a=%0d b=%0d exp 0", use_rst, vcnt_a - va, vcnt_b - vb);
        end
        checks++;
        if (bus_a.addr !== 10'd448 || bus_b.addr !== 10'd448 || bus_a.dout !== '0 || bus_b.dout !== '0) begin
            errors++;
            $display("FAIL abort_state rst=%0b got addr a=%0d b=%0d dout a=%h b=%h exp 448/0",
                     use_rst, bus_a.addr, bus_b.addr, bus_a.dout, bus_b.dout);
        end
        check_flags("abort");
        do_sample(1'b0);        // no credit left: muted
        check_flags("abort_mute");
    endtask

    task automatic test_random();
        clr_dut();
        repeat (250) begin
            if ($urandom_range(0, 3) == 0) pulse_fd();
            else do_sample(1'b0);
        end
        check_flags("random");
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_ring();
        test_underrun();
        test_overflow();
        test_missed();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
